// File: rtl/i2c_slave.sv
// I2C slave: 7-bit address, write bytes to RX_DATA, return TX_DATA on reads.
// SCL/SDA are oversampled on BUS_CLK through a two-flop synchronizer plus a
// history flop; all bus events are derived from the synchronized samples.
`timescale 1ns/1ps
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h20
) (
   input  logic       BUS_CLK,
   input  logic       BUS_RST,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   input  logic [7:0] TX_DATA,
   output logic       TX_LOAD,
   output logic       BUSY
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      WRITE     = 3'd3,
      WRITE_ACK = 3'd4,
      READ      = 3'd5,
      READ_ACK  = 3'd6,
      IGNORE    = 3'd7
   } state_t;

   state_t      state;
   logic        scl_sync1, scl_sync2, scl_hist;
   logic        sda_sync1, sda_sync2, sda_hist;
   logic        sda_low;     // 1 = pull SDA low, 0 = release
   logic [2:0]  bit_cnt;
   logic [6:0]  shift;       // bits already received / bits still to send
   logic        rw;
   logic        ack_seen;

   logic        scl_rise, scl_fall, start_evt, stop_evt;

   // Open drain: only ever drive a 0, otherwise release the line.
   assign i2c_sda = sda_low ? 1'b0 : 1'bz;

   assign scl_rise  =  scl_sync2 & ~scl_hist;
   assign scl_fall  = ~scl_sync2 &  scl_hist;
   assign start_evt =  scl_sync2 &  sda_hist & ~sda_sync2;
   assign stop_evt  =  scl_sync2 & ~sda_hist &  sda_sync2;

   // Synchronize SCL/SDA and keep one history sample for edge detection.
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         scl_sync1 <= 1'b1;
         scl_sync2 <= 1'b1;
         scl_hist  <= 1'b1;
         sda_sync1 <= 1'b1;
         sda_sync2 <= 1'b1;
         sda_hist  <= 1'b1;
      end else begin
         scl_sync1 <= i2c_scl;
         scl_sync2 <= scl_sync1;
         scl_hist  <= scl_sync2;
         sda_sync1 <= i2c_sda;
         sda_sync2 <= sda_sync1;
         sda_hist  <= sda_sync2;
      end
   end

   // Protocol FSM with registered SDA drive and status outputs.
   // ACK states are entered at the 8th rise; the first fall inside them
   // starts the ACK drive, the second fall ends it. BUSY marks the span in
   // which the address has matched, so a foreign address never raises it.
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state    <= IDLE;
         sda_low  <= 1'b0;
         bit_cnt  <= 3'd0;
         shift    <= 7'd0;
         rw       <= 1'b0;
         ack_seen <= 1'b0;
         RX_DATA  <= 8'd0;
         RX_VALID <= 1'b0;
         TX_LOAD  <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         RX_VALID <= 1'b0;
         TX_LOAD  <= 1'b0;
         if (start_evt) begin
            // START beats any sample that coincides with it.
            state   <= ADDR;
            bit_cnt <= 3'd0;
            sda_low <= 1'b0;
            BUSY    <= 1'b0;
         end else if (stop_evt) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            sda_low <= 1'b0;
            BUSY    <= 1'b0;
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     shift   <= {shift[5:0], sda_sync2};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (shift == SLAVE_ADDR) begin
                           state <= ADDR_ACK;
                           rw    <= sda_sync2;
                           BUSY  <= 1'b1;
                        end else begin
                           state <= IGNORE;
                        end
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_low) begin
                        sda_low <= 1'b1;
                     end else if (rw) begin
                        shift   <= TX_DATA[6:0];
                        sda_low <= ~TX_DATA[7];
                        TX_LOAD <= 1'b1;
                        bit_cnt <= 3'd0;
                        state   <= READ;
                     end else begin
                        sda_low <= 1'b0;
                        state   <= WRITE;
                     end
                  end
               end
               WRITE: begin
                  if (scl_rise) begin
                     shift   <= {shift[5:0], sda_sync2};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        RX_DATA  <= {shift, sda_sync2};
                        RX_VALID <= 1'b1;
                        state    <= WRITE_ACK;
                     end
                  end
               end
               WRITE_ACK: begin
                  if (scl_fall) begin
                     if (!sda_low) begin
                        sda_low <= 1'b1;
                     end else begin
                        sda_low <= 1'b0;
                        state   <= WRITE;
                     end
                  end
               end
               READ: begin
                  if (scl_fall) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        sda_low  <= 1'b0;
                        ack_seen <= 1'b0;
                        state    <= READ_ACK;
                     end else begin
                        sda_low <= ~shift[6];
                        shift   <= {shift[5:0], 1'b0};
                     end
                  end
               end
               READ_ACK: begin
                  if (scl_rise) begin
                     if (sda_sync2) begin
                        state <= IGNORE;
                        BUSY  <= 1'b0;
                     end else begin
                        ack_seen <= 1'b1;
                     end
                  end else if (scl_fall && ack_seen) begin
                     shift   <= TX_DATA[6:0];
                     sda_low <= ~TX_DATA[7];
                     TX_LOAD <= 1'b1;
                     bit_cnt <= 3'd0;
                     state   <= READ;
                  end
               end
               IDLE, IGNORE: begin
                  sda_low <= 1'b0;
               end
               default: begin
                  state   <= IDLE;
                  sda_low <= 1'b0;
                  BUSY    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed + randomized bench for i2c_slave: a bus-level master drives SCL/SDA
// and a transaction-level model predicts ACKs, received bytes and load counts.
`timescale 1ns/1ps
module tb_i2c_slave;

   localparam logic [6:0] ADDR = 7'h20;
   localparam int         Q    = 50;   // quarter SCL period (SCL = 200 ns)

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_valid, tx_load, busy;
   wire        sda;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
      .BUS_CLK (clk),
      .BUS_RST (rst),
      .i2c_scl (scl),
      .i2c_sda (sda),
      .RX_DATA (rx_data),
      .RX_VALID(rx_valid),
      .TX_DATA (tx_data),
      .TX_LOAD (tx_load),
      .BUSY    (busy)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] rx_log[$];
   logic [7:0] tx_bytes[$];
   int         tx_idx = 0;
   int         tx_load_cnt = 0;
   int         slave_low_cnt = 0;
   int         busy_cnt = 0;

   // Monitor on the inactive edge: log pulses and feed the next read byte.
   always @(negedge clk) begin
      if (rx_valid) rx_log.push_back(rx_data);
      if (tx_load) begin
         tx_load_cnt = tx_load_cnt + 1;
         tx_idx = tx_idx + 1;
      end
      tx_data = (tx_idx < tx_bytes.size()) ? tx_bytes[tx_idx] : 8'h00;
      if (!m_low && sda === 1'b0) slave_low_cnt = slave_low_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bit_out(input logic b);
      m_low = ~b;
      #Q scl = 1'b1;
      #(2*Q) scl = 1'b0;
      #Q;
   endtask

   task automatic start_cond();
      m_low = 1'b0;
      #Q scl = 1'b1;
      #Q m_low = 1'b1;
      #Q scl = 1'b0;
      #Q;
   endtask

   task automatic stop_cond();
      m_low = 1'b1;
      #Q scl = 1'b1;
      #Q m_low = 1'b0;
      #(2*Q);
   endtask

   // Send 8 bits and return the level seen on the 9th clock (0 = ACK).
   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) bit_out(b[i]);
      m_low = 1'b0;
      #Q scl = 1'b1;
      #Q ack = sda;
      #Q scl = 1'b0;
      #Q;
   endtask

   // Clock in 8 bits, then drive ACK (give_ack=1) or NACK on the 9th clock.
   task automatic read_byte(input logic give_ack, output logic [7:0] b);
      m_low = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         #Q scl = 1'b1;
         #Q b[i] = sda;
         #Q scl = 1'b0;
         #Q;
      end
      m_low = give_ack;
      #Q scl = 1'b1;
      #(2*Q) scl = 1'b0;
      #Q m_low = 1'b0;
   endtask

   // Write transaction checked against the model: ACKs only when addressed,
   // and every written byte appears once on RX_DATA in order.
   task automatic do_write(input logic [6:0] a, input int n, input logic [31:0] data);
      int   rx_base;
      logic hit;
      logic ack;
      rx_base = rx_log.size();
      hit = (a == ADDR);
      start_cond();
      send_byte({a, 1'b0}, ack);
      check("w_addr_ack", {31'd0, ack}, {31'd0, ~hit});
      check("w_busy_mid", {31'd0, busy}, {31'd0, hit});
      for (int k = 0; k < n; k++) begin
         send_byte(data[k*8 +: 8], ack);
         check("w_data_ack", {31'd0, ack}, {31'd0, ~hit});
      end
      stop_cond();
      check("w_rx_count", rx_log.size() - rx_base, hit ? n : 0);
      for (int k = 0; k < rx_log.size() - rx_base; k++)
         check("w_rx_byte", {24'd0, rx_log[rx_base + k]}, {24'd0, data[k*8 +: 8]});
      check("w_busy_end", {31'd0, busy}, 32'd0);
   endtask

   // Read transaction: master ACKs all bytes but the last.
   task automatic do_read(input logic [6:0] a, input int n, input logic [31:0] data);
      int         tl_base;
      logic       hit;
      logic       ack;
      logic [7:0] b;
      hit = (a == ADDR);
      if (hit) for (int k = 0; k < n; k++) tx_bytes.push_back(data[k*8 +: 8]);
      @(negedge clk);
      #1;
      tl_base = tx_load_cnt;
      start_cond();
      send_byte({a, 1'b1}, ack);
      check("r_addr_ack", {31'd0, ack}, {31'd0, ~hit});
      check("r_first_load", tx_load_cnt - tl_base, hit ? 1 : 0);
      check("r_busy_mid", {31'd0, busy}, {31'd0, hit});
      for (int k = 0; k < n; k++) begin
         read_byte(k != n - 1, b);
         check("r_byte", {24'd0, b}, hit ? {24'd0, data[k*8 +: 8]} : 32'hFF);
      end
      check("r_sda_rel_nack", {31'd0, sda}, 32'd1);
      stop_cond();
      check("r_load_count", tx_load_cnt - tl_base, hit ? n : 0);
      check("r_busy_end", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int         base_a, base_b, base_c;
      logic       ack;
      logic [7:0] b;
      logic [6:0] ra;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_tx_load", {31'd0, tx_load}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sda", {31'd0, sda}, 32'd1);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Write 0x40 then 0xA5.
      do_write(ADDR, 1, 32'h0000_00A5);

      // Foreign address 0x21: no drive, no data, BUSY never rises.
      base_a = slave_low_cnt;
      base_b = busy_cnt;
      base_c = rx_log.size();
      do_write(7'h21, 1, 32'h0000_00FF);
      check("na_sda_driven", slave_low_cnt - base_a, 32'd0);
      check("na_busy_seen", busy_cnt - base_b, 32'd0);
      check("na_rx", rx_log.size() - base_c, 32'd0);

      // Read 0x3C, 0xC3 with ACK then NACK.
      do_read(ADDR, 2, 32'h0000_C33C);

      // Write 0x11, repeated START, read one byte.
      base_a = rx_log.size();
      tx_bytes.push_back(8'h77);
      @(negedge clk);
      #1;
      base_b = tx_load_cnt;
      start_cond();
      send_byte({ADDR, 1'b0}, ack);
      check("sr_w_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h11, ack);
      check("sr_d_ack", {31'd0, ack}, 32'd0);
      start_cond();
      send_byte({ADDR, 1'b1}, ack);
      check("sr_r_ack", {31'd0, ack}, 32'd0);
      check("sr_load", tx_load_cnt - base_b, 32'd1);
      read_byte(1'b0, b);
      check("sr_byte", {24'd0, b}, 32'h77);
      stop_cond();
      check("sr_rx_count", rx_log.size() - base_a, 32'd1);
      check("sr_rx_val", {24'd0, rx_log[base_a]}, 32'h11);

      // Reset while the slave drives the address ACK.
      start_cond();
      for (int i = 7; i >= 0; i--) bit_out(((8'h40 >> i) & 8'h01) != 8'h00);
      m_low = 1'b0;
      #Q scl = 1'b1;
      #Q;
      check("mr_ack_driven", {31'd0, sda}, 32'd0);
      rst = 1'b1;
      #1;
      check("mr_sda_release", {31'd0, sda}, 32'd1);
      check("mr_busy", {31'd0, busy}, 32'd0);
      #(Q - 1) rst = 1'b0;
      #Q scl = 1'b0;
      #Q;
      base_a = slave_low_cnt;
      base_b = rx_log.size();
      for (int i = 0; i < 10; i++) bit_out(i[0]);
      m_low = 1'b0;
      #Q;
      check("mr_ignore_drive", slave_low_cnt - base_a, 32'd0);
      check("mr_ignore_rx", rx_log.size() - base_b, 32'd0);
      do_write(ADDR, 1, 32'h0000_005A);

      // STOP after 4 data bits of a write.
      base_a = rx_log.size();
      start_cond();
      send_byte({ADDR, 1'b0}, ack);
      check("ms_addr_ack", {31'd0, ack}, 32'd0);
      bit_out(1'b1);
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b0);
      stop_cond();
      check("ms_rx", rx_log.size() - base_a, 32'd0);
      check("ms_busy", {31'd0, busy}, 32'd0);
      check("ms_sda", {31'd0, sda}, 32'd1);

      // Randomized transactions against the model.
      for (int it = 0; it < 6; it++) begin
         ra = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
         do_write(ra, int'($urandom_range(1, 4)), $urandom);
         ra = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
         do_read(ra, int'($urandom_range(1, 4)), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
